// File: rtl/select_out_fanout.sv
// -----------------------------------------------------------------------------
// select_out_fanout
//
// Round-robin scatter/gather buffer. Accepted words are written to NUM_LANES
// independent FIFO lanes (DEPTH entries each), one lane per word. The write
// lane advances over the set bits of active_mask. Reads follow the same
// rotation, so the output order always equals the input order. Outputs come
// from registered FIFO state only. There is no combinational say-to-heard path.
//
// Parameters:
//   WIDTH      payload width in bits
//   NUM_LANES  number of lanes (2..16)
//   DEPTH      entries per lane, power of two, >= 1
//   LANE_W     width of the heard_lane field
//
// Ports:
//   CLK, nRST      clock (rising edge) / asynchronous active-low reset
//   say__ENA       input transfer request
//   say_v          input payload
//   say__RDY       lane at the write index can accept
//   heard__ENA     output valid (lane at the read index not empty)
//   heard_v        output payload, 0 when heard__ENA=0
//   heard_lane     lane the output came from, 0 when heard__ENA=0
//   heard__RDY     consumer accepts
//   lane_mask      requested enabled-lane set
//   mask_update    request to load lane_mask (honoured only when idle)
//   active_mask    lane mask currently in force
//   idle           all lanes empty
//
// Optional feature, macro SELECT_OUT_FANOUT_STATS_EN:
//   adds 32-bit wrapping counters stat_in (accepts), stat_out (transfers)
//   and stat_stall (cycles with say__ENA && !say__RDY). It also prints a
//   trace line on every accept.
// -----------------------------------------------------------------------------
module select_out_fanout #(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 2,
  parameter int LANE_W    = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 say__ENA,
  input  logic [WIDTH-1:0]     say_v,
  output logic                 say__RDY,
  output logic                 heard__ENA,
  output logic [WIDTH-1:0]     heard_v,
  output logic [LANE_W-1:0]    heard_lane,
  input  logic                 heard__RDY,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 mask_update,
  output logic [NUM_LANES-1:0] active_mask,
`ifdef SELECT_OUT_FANOUT_STATS_EN
  output logic [31:0]          stat_in,
  output logic [31:0]          stat_out,
  output logic [31:0]          stat_stall,
`endif
  output logic                 idle
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIW = $clog2(NUM_LANES);

  typedef logic [PW-1:0]  ptr_t;
  typedef logic [LIW-1:0] lane_t;

  // XOR pattern of write and read pointers for a full lane: wrap bits
  // differ and all address bits are equal.
  localparam ptr_t FULL_XOR = ptr_t'(1) << (PW - 1);

  ptr_t                   r_wr_ptr [NUM_LANES];
  ptr_t                   r_rd_ptr [NUM_LANES];
  logic [WIDTH-1:0]       r_mem    [NUM_LANES][DEPTH];
  lane_t                  r_windex;
  lane_t                  r_rindex;
  logic [NUM_LANES-1:0]   r_active_mask;

  logic [NUM_LANES-1:0]   w_empty;
  logic [NUM_LANES-1:0]   w_full;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_mask_load;
  lane_t                  w_mask_low;

  // Storage address inside a lane. For DEPTH=1 this is always 0.
  function automatic logic [IW-1:0] addr_of(input ptr_t p);
    return IW'(p) & IW'(DEPTH - 1);
  endfunction

  // Next set bit of mask above cur, wrapping to the lowest set bit. If cur is
  // the only set bit, the function returns cur.
  function automatic lane_t next_lane(input logic [NUM_LANES-1:0] mask,
                                      input lane_t cur);
    lane_t res;
    logic  found;
    int    j;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      j = (int'(cur) + k) % NUM_LANES;
      if (!found && mask[j]) begin
        res   = lane_t'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic lane_t lowest_lane(input logic [NUM_LANES-1:0] mask);
    lane_t res;
    res = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (mask[k]) res = lane_t'(k);
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // logic. This way no path can leave it unassigned and infer a latch.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_empty[l] = (r_wr_ptr[l] == r_rd_ptr[l]);
      w_full[l]  = ((r_wr_ptr[l] ^ r_rd_ptr[l]) == FULL_XOR);
    end
  end

  // A full lane stays not-ready even when it is popped in the same cycle.
  assign say__RDY    = !w_full[r_windex];
  assign heard__ENA  = !w_empty[r_rindex];
  assign heard_v     = heard__ENA ? r_mem[r_rindex][addr_of(r_rd_ptr[r_rindex])]
                                  : '0;
  assign heard_lane  = heard__ENA ? LANE_W'(r_rindex) : '0;
  assign idle        = &w_empty;
  assign active_mask = r_active_mask;

  assign w_accept    = say__ENA && say__RDY;
  assign w_xfer      = heard__ENA && heard__RDY;
  // A mask change is only safe when nothing is buffered. Otherwise the
  // rotation would lose track of the oldest word. A request that cannot be
  // honoured is dropped, and the requester has to retry.
  assign w_mask_load = mask_update && idle && !w_accept && (|lane_mask);
  assign w_mask_low  = lowest_lane(lane_mask);

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever order the blocks
  // evaluate in.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_wr_ptr[l] <= '0;
        r_rd_ptr[l] <= '0;
      end
      r_windex      <= '0;
      r_rindex      <= '0;
      r_active_mask <= '1;
    end else begin
      if (w_accept) begin
        r_wr_ptr[r_windex] <= r_wr_ptr[r_windex] + ptr_t'(1);
        r_windex           <= next_lane(r_active_mask, r_windex);
      end
      if (w_xfer) begin
        r_rd_ptr[r_rindex] <= r_rd_ptr[r_rindex] + ptr_t'(1);
        r_rindex           <= next_lane(r_active_mask, r_rindex);
      end
      // A load implies idle (no transfer) and no accept, so it never
      // competes with the index updates above.
      if (w_mask_load) begin
        r_active_mask <= lane_mask;
        r_windex      <= w_mask_low;
        r_rindex      <= w_mask_low;
      end
    end
  end

  // NOTE: payload storage is intentionally left without reset. The pointers
  // alone decide validity, and unreset RAM maps onto plain memory cells.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_mem[r_windex][addr_of(r_wr_ptr[r_windex])] <= say_v;
    end
  end

`ifdef SELECT_OUT_FANOUT_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_in    <= '0;
      stat_out   <= '0;
      stat_stall <= '0;
    end else begin
      if (w_accept)              stat_in    <= stat_in + 32'd1;
      if (w_xfer)                stat_out   <= stat_out + 32'd1;
      if (say__ENA && !say__RDY) stat_stall <= stat_stall + 32'd1;
    end
  end

  // Trace of each accepted word. The occupancy shown is the count before
  // this write.
  always @(posedge CLK) begin
    if (nRST && w_accept) begin
      $display("select_out_fanout: accept payload=0x%0h lane=%0d occupancy=%0d",
               say_v, r_windex, r_wr_ptr[r_windex] - r_rd_ptr[r_windex]);
    end
  end
`endif

endmodule

// File: tb/tb_select_out_fanout.sv
// -----------------------------------------------------------------------------
// tb_select_out_fanout
//
// Bench for select_out_fanout with the default parameters (4 lanes, depth 2).
// The reference model is a set of per-lane queues plus write/read lane
// numbers and a mask. On every falling edge, the DUT outputs are compared
// against that model. Directed scenarios also pin the model with literal
// expectations (output order, lane sequences, accept counts).
// -----------------------------------------------------------------------------
module tb_select_out_fanout;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int LW = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          say__ENA;
  logic [W-1:0]  say_v;
  logic          say__RDY;
  logic          heard__ENA;
  logic [W-1:0]  heard_v;
  logic [LW-1:0] heard_lane;
  logic          heard__RDY;
  logic [N-1:0]  lane_mask;
  logic          mask_update;
  logic [N-1:0]  active_mask;
  logic          idle;
`ifdef SELECT_OUT_FANOUT_STATS_EN
  logic [31:0]   stat_in;
  logic [31:0]   stat_out;
  logic [31:0]   stat_stall;
`endif

  select_out_fanout #(.WIDTH(W), .NUM_LANES(N), .DEPTH(D), .LANE_W(LW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .say__ENA    (say__ENA),
    .say_v       (say_v),
    .say__RDY    (say__RDY),
    .heard__ENA  (heard__ENA),
    .heard_v     (heard_v),
    .heard_lane  (heard_lane),
    .heard__RDY  (heard__RDY),
    .lane_mask   (lane_mask),
    .mask_update (mask_update),
    .active_mask (active_mask),
`ifdef SELECT_OUT_FANOUT_STATS_EN
    .stat_in     (stat_in),
    .stat_out    (stat_out),
    .stat_stall  (stat_stall),
`endif
    .idle        (idle)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] mq [N][$];
  int           m_w;
  int           m_r;
  logic [N-1:0] m_mask;

  typedef struct {
    logic [LW-1:0] lane;
    logic [W-1:0]  data;
  } obs_t;
  obs_t obs[$];          // transfers seen on the DUT output
  int   n_acc;           // accepts seen on the DUT
  int   n_stall;         // stall cycles seen on the DUT
  bit   cmp_en = 1'b0;

  function automatic int nxt(input logic [N-1:0] mask, input int idx);
    for (int k = 1; k <= N; k++) begin
      if (mask[(idx + k) % N]) return (idx + k) % N;
    end
    return idx;
  endfunction

  function automatic int lowest(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[k]) return k;
    end
    return 0;
  endfunction

  function automatic bit m_idle();
    for (int l = 0; l < N; l++) begin
      if (mq[l].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int l = 0; l < N; l++) mq[l].delete();
      m_w    = 0;
      m_r    = 0;
      m_mask = '1;
    end else begin
      bit acc;
      bit xfer;
      bit ld;
      acc  = say__ENA && (mq[m_w].size() < D);
      xfer = heard__RDY && (mq[m_r].size() > 0);
      ld   = mask_update && m_idle() && !acc && (lane_mask != '0);
      if (heard__ENA && heard__RDY) obs.push_back(obs_t'{heard_lane, heard_v});
      if (say__ENA && say__RDY)     n_acc++;
      if (say__ENA && !say__RDY)    n_stall++;
      if (xfer) begin
        void'(mq[m_r].pop_front());
        m_r = nxt(m_mask, m_r);
      end
      if (acc) begin
        mq[m_w].push_back(say_v);
        m_w = nxt(m_mask, m_w);
      end
      if (ld) begin
        m_mask = lane_mask;
        m_w    = lowest(lane_mask);
        m_r    = lowest(lane_mask);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      bit has;
      has = (mq[m_r].size() != 0);
      check("say__RDY",    say__RDY,    mq[m_w].size() < D);
      check("heard__ENA",  heard__ENA,  has);
      check("heard_v",     heard_v,     has ? mq[m_r][0] : '0);
      check("heard_lane",  heard_lane,  has ? LW'(m_r) : '0);
      check("active_mask", active_mask, m_mask);
      check("idle",        idle,        m_idle());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int t;
    say__ENA   = 1'b0;
    heard__RDY = 1'b1;
    t = 0;
    while (!idle && t < budget) begin
      tick();
      t++;
    end
    if (!idle) check("drain_timeout", idle, 1'b1);
  endtask

  task automatic load_mask(input logic [N-1:0] m);
    lane_mask   = m;
    mask_update = 1'b1;
    tick();
    mask_update = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sent[$];
    logic [31:0]  b_in, b_out, b_stall;
    nRST        = 1'b0;
    say__ENA    = 1'b0;
    say_v       = '0;
    heard__RDY  = 1'b0;
    lane_mask   = '0;
    mask_update = 1'b0;
    b_in = 0; b_out = 0; b_stall = 0;

    // Reset values
    #12;
    check("rst_say__RDY",    say__RDY,    1'b1);
    check("rst_heard__ENA",  heard__ENA,  1'b0);
    check("rst_heard_v",     heard_v,     '0);
    check("rst_heard_lane",  heard_lane,  '0);
    check("rst_idle",        idle,        1'b1);
    check("rst_active_mask", active_mask, 4'hF);
    @(negedge CLK);
    nRST   = 1'b1;
    cmp_en = 1'b1;

    // 1: eight words in order, lane rotation 0..3
    obs.delete();
    heard__RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      say__ENA = 1'b1;
      say_v    = W'(32'h10 + i);
      tick();
    end
    drain(40);
    check("t1_count", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check("t1_data", obs[i].data, 32'h10 + i);
      check("t1_lane", obs[i].lane, i % 4);
    end

    // 2: fill until stall, then drain in order
    obs.delete();
    n_acc      = 0;
    heard__RDY = 1'b0;
    say__ENA   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      say_v = W'(32'h100 + i);
      tick();
    end
    check("t2_accepts", n_acc, 8);
    check("t2_stalled", say__RDY, 1'b0);
    check("t2_not_idle", idle, 1'b0);
    drain(40);
    check("t2_idle", idle, 1'b1);
    check("t2_count", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check("t2_data", obs[i].data, 32'h100 + i);
    end

    // 3: mask 1010 while idle, lanes 1,3,1
    load_mask(4'b1010);
    check("t3_active_mask", active_mask, 4'b1010);
    obs.delete();
    heard__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      say__ENA = 1'b1;
      say_v    = W'(32'hA + i);
      tick();
    end
    drain(40);
    check("t3_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("t3_lane0", obs[0].lane, 1);
      check("t3_lane1", obs[1].lane, 3);
      check("t3_lane2", obs[2].lane, 1);
      check("t3_data2", obs[2].data, 32'hC);
    end

    // 4: ignored mask updates (not idle, then zero mask)
    heard__RDY = 1'b0;
    say__ENA   = 1'b1;
    say_v      = 32'h77;
    tick();
    say__ENA = 1'b0;
    check("t4_buffered", idle, 1'b0);
    load_mask(4'b0101);
    check("t4_busy_ignored", active_mask, 4'b1010);
    drain(40);
    load_mask(4'b0000);
    check("t4_zero_ignored", active_mask, 4'b1010);
    load_mask(4'b1111);
    check("t4_restore", active_mask, 4'b1111);

    // 5: continuous push/pop for 100 cycles
    obs.delete();
    sent.delete();
    n_stall = 0;
`ifdef SELECT_OUT_FANOUT_STATS_EN
    b_in = stat_in; b_out = stat_out; b_stall = stat_stall;
`endif
    heard__RDY = 1'b1;
    check("t5_empty_before", heard__ENA, 1'b0);
    for (int i = 0; i < 100; i++) begin
      say__ENA = 1'b1;
      say_v    = $urandom;
      sent.push_back(say_v);
      tick();
      if (i == 0) check("t5_latency1", heard__ENA, 1'b1);
    end
    drain(40);
    check("t5_stalls", n_stall, 0);
    check("t5_count", obs.size(), 100);
    for (int i = 0; i < 100 && i < obs.size(); i++) begin
      check("t5_data", obs[i].data, sent[i]);
    end
`ifdef SELECT_OUT_FANOUT_STATS_EN
    check("t5_stat_in",    stat_in - b_in,       100);
    check("t5_stat_out",   stat_out - b_out,     100);
    check("t5_stat_stall", stat_stall - b_stall, 0);
`endif

    // 6: random soak with occasional mask updates
    for (int i = 0; i < 400; i++) begin
      say__ENA    = ($urandom % 2) != 0;
      say_v       = $urandom;
      heard__RDY  = ($urandom % 4) != 0;
      lane_mask   = N'($urandom);
      mask_update = ($urandom % 12) == 0;
      tick();
    end
    mask_update = 1'b0;
    drain(60);
    load_mask(4'b1111);
    check("t6_restore", active_mask, 4'b1111);

    // 7: asynchronous reset mid-burst
    heard__RDY = 1'b0;
    say__ENA   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      say_v = W'(32'h200 + i);
      tick();
    end
    #2;
    nRST = 1'b0;
    #1;
    check("t7_heard__ENA", heard__ENA, 1'b0);
    check("t7_say__RDY",   say__RDY,   1'b1);
    check("t7_idle",       idle,       1'b1);
    check("t7_heard_v",    heard_v,    '0);
    say__ENA = 1'b0;
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    obs.delete();
    heard__RDY = 1'b1;
    say__ENA   = 1'b1;
    say_v      = 32'h55;
    tick();
    drain(20);
    check("t7_count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("t7_lane", obs[0].lane, 0);
      check("t7_data", obs[0].data, 32'h55);
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
